// File: rtl/pwm_audio_out.sv
// Single-pin PWM audio DAC: 8-bit samples into a one-entry holding buffer,
// 256 ticks per frame, duty latched only at frame boundaries, sample_req per frame.
module pwm_audio_out #(
  parameter int DIV = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_valid,
  input  logic [7:0] sample_in,
  output logic       sample_req,
  output logic       pwm_out,
  output logic       overrun
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [7:0]    duty_q, duty_d;
  logic [7:0]    hold_q, hold_d;
  logic          pending_q, pending_d;
  logic          req_q, req_d;
  logic          pwm_q, pwm_d;
  logic          ovr_q, ovr_d;

  logic tick;
  logic frame_end;

  assign tick      = (pre_q == PRE_MAX);
  assign frame_end = tick && (cnt_q == 8'hFF);

  always_comb begin
    pre_d     = tick ? '0 : pre_q + 1'b1;
    cnt_d     = tick ? cnt_q + 8'd1 : cnt_q;
    duty_d    = duty_q;
    hold_d    = hold_q;
    pending_d = pending_q;
    ovr_d     = ovr_q;
    req_d     = frame_end;
    // Compare uses the current cnt/duty, so the pin trails them by one clock.
    pwm_d     = (cnt_q < duty_q);

    // Boundary consumes the OLD hold value even if a new sample lands this cycle.
    if (frame_end) begin
      if (pending_q) begin
        duty_d = hold_q;
      end
      pending_d = 1'b0;
    end

    if (sample_valid) begin
      hold_d    = sample_in;
      pending_d = 1'b1;
      if (pending_q && !frame_end) begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q     <= '0;
      cnt_q     <= '0;
      duty_q    <= '0;
      hold_q    <= '0;
      pending_q <= 1'b0;
      req_q     <= 1'b0;
      pwm_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      pre_q     <= pre_d;
      cnt_q     <= cnt_d;
      duty_q    <= duty_d;
      hold_q    <= hold_d;
      pending_q <= pending_d;
      req_q     <= req_d;
      pwm_q     <= pwm_d;
      ovr_q     <= ovr_d;
    end
  end

  assign sample_req = req_q;
  assign pwm_out    = pwm_q;
  assign overrun    = ovr_q;

endmodule
